regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Two-source (ALU / MEM) round-robin arbiter feeding the single
//             register-file write port through per-source FIFOs.
//             Optional pending-write mask enabled by REGWR_PENDING_EN.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [4:0]            alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [4:0]            mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wr_hold,
    output logic                  reg_write,
    output logic [4:0]            write_register,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  wr_src,
    output logic [31:0]           pending
);

    localparam int   PTR_W     = $clog2(FIFO_DEPTH);
    localparam int   CNT_W     = PTR_W + 1;
    localparam logic c_SRC_ALU = 1'b0;
    localparam logic c_SRC_MEM = 1'b1;

    // Index 0 is the ALU source, index 1 the MEM source.
    logic [1:0]                 w_pushValid;
    logic [1:0][4:0]            w_pushAddr;
    logic [1:0][DATA_WIDTH-1:0] w_pushData;
    logic [1:0]                 w_full;
    logic [1:0]                 w_empty;
    logic [1:0]                 w_pop;
    logic [1:0][4:0]            w_headAddr;
    logic [1:0][DATA_WIDTH-1:0] w_headData;
`ifdef REGWR_PENDING_EN
    logic [1:0][31:0]           w_fifoPend;
`endif

    assign w_pushValid = {mem_valid, alu_valid};
    assign w_pushAddr  = {mem_addr, alu_addr};
    assign w_pushData  = {mem_data, alu_data};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_fifo
            logic [4:0]            r_addrMem [FIFO_DEPTH];
            logic [DATA_WIDTH-1:0] r_dataMem [FIFO_DEPTH];
            logic [PTR_W-1:0]      r_wrPtr;
            logic [PTR_W-1:0]      r_rdPtr;
            logic [CNT_W-1:0]      r_count;
            logic                  w_push;

            // Full blocks a push even if the same cycle pops, so ready stays purely registered.
            assign w_full[i]     = (r_count == CNT_W'(FIFO_DEPTH));
            assign w_empty[i]    = (r_count == '0);
            assign w_push        = w_pushValid[i] && !w_full[i];
            assign w_headAddr[i] = r_addrMem[r_rdPtr];
            assign w_headData[i] = r_dataMem[r_rdPtr];

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_addrMem[r_wrPtr] <= w_pushAddr[i];
                    r_dataMem[r_wrPtr] <= w_pushData[i];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wrPtr <= '0;
                    r_rdPtr <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) begin
                        r_wrPtr <= r_wrPtr + PTR_W'(1);
                    end
                    if (w_pop[i]) begin
                        r_rdPtr <= r_rdPtr + PTR_W'(1);
                    end
                    case ({w_push, w_pop[i]})
                        2'b10:   r_count <= r_count + CNT_W'(1);
                        2'b01:   r_count <= r_count - CNT_W'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

`ifdef REGWR_PENDING_EN
            logic [31:0] w_pendLocal;

            // A slot is live when its distance from the read pointer is below the occupancy.
            always_comb begin
                w_pendLocal = '0;
                for (int s = 0; s < FIFO_DEPTH; s++) begin
                    if ({1'b0, PTR_W'(PTR_W'(s) - r_rdPtr)} < r_count) begin
                        w_pendLocal[r_addrMem[s]] = 1'b1;
                    end
                end
            end

            assign w_fifoPend[i] = w_pendLocal;
`endif
        end
    endgenerate

    logic                  w_grant;
    logic                  w_grantMem;
    logic [4:0]            w_selAddr;
    logic [DATA_WIDTH-1:0] w_selData;
    logic                  r_lastGrant;
    logic                  r_regWrite;
    logic [4:0]            r_writeRegister;
    logic [DATA_WIDTH-1:0] r_writeData;
    logic                  r_wrSrc;

    assign w_grant    = !wr_hold && (!w_empty[0] || !w_empty[1]);
    assign w_grantMem = (!w_empty[0] && !w_empty[1]) ? (r_lastGrant == c_SRC_ALU) : w_empty[0];
    assign w_pop      = {w_grant && w_grantMem, w_grant && !w_grantMem};
    assign w_selAddr  = w_grantMem ? w_headAddr[1] : w_headAddr[0];
    assign w_selData  = w_grantMem ? w_headData[1] : w_headData[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant     <= c_SRC_MEM;
            r_regWrite      <= 1'b0;
            r_writeRegister <= '0;
            r_writeData     <= '0;
            r_wrSrc         <= c_SRC_ALU;
        end else begin
            r_regWrite <= w_grant && (w_selAddr != 5'd0);
            if (w_grant) begin
                r_lastGrant <= w_grantMem;
                r_wrSrc     <= w_grantMem;
                // r0 entries are swallowed: the port keeps its last address and data.
                if (w_selAddr != 5'd0) begin
                    r_writeRegister <= w_selAddr;
                    r_writeData     <= w_selData;
                end
            end
        end
    end

    assign alu_ready      = !w_full[0];
    assign mem_ready      = !w_full[1];
    assign reg_write      = r_regWrite;
    assign write_register = r_writeRegister;
    assign write_data     = r_writeData;
    assign wr_src         = r_wrSrc;

`ifdef REGWR_PENDING_EN
    logic [31:0] w_pend;

    always_comb begin
        w_pend = w_fifoPend[0] | w_fifoPend[1];
        if (r_regWrite) begin
            w_pend[r_writeRegister] = 1'b1;
        end
        w_pend[0] = 1'b0;
    end

    assign pending = w_pend;
`else
    assign pending = '0;
`endif

endmodule
`default_nettype wire
